// File: rtl/aes_pkg.sv
// aes_pkg: shared AES key-schedule constants, word type and byte/word helpers.
package aes_pkg;
    localparam int NR = 14;
    localparam int NK = 8;
    localparam logic [7:0] RCON_INIT = 8'h01;
    localparam logic [7:0] XTIME_POLY = 8'h1b;

    typedef logic [31:0] word_t;

    function automatic word_t rot_word(input word_t w);
        return {w[23:0], w[31:24]};
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? XTIME_POLY : 8'h00);
    endfunction
endpackage

// File: rtl/sbox.sv
// sbox: combinational AES forward S-box, one byte in, one byte out.
module sbox (
    input  logic [7:0] i_byte,
    output logic [7:0] o_byte
);
    localparam logic [0:255][7:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };
    assign o_byte = SBOX[i_byte];
endmodule

// File: rtl/aes256_key_expand.sv
// aes256_key_expand: sequential AES-256 key schedule, one 128-bit round key per handshake.
// An 8-word sliding window holds w[i-8..i-1]; each GEN cycle appends four words.
module aes256_key_expand
    import aes_pkg::*;
(
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic [255:0]   key,
    output logic           busy,
    output logic           rk_valid,
    input  logic           rk_ready,
    output logic [3:0]     rk_idx,
    output logic [127:0]   rk,
    output logic           done
);
    typedef enum logic [1:0] {IDLE, EMIT, GEN} state_t;

    state_t              r_state;
    logic [32*NK-1:0]    r_win;
    logic [7:0]          r_rcon;
    logic                w_even;
    word_t               w_sub_in, w_sub, w_temp, w_n0, w_n1, w_n2, w_n3;

    // The key being generated is rk_idx+1, so an odd current index means an even new one.
    assign w_even   = rk_idx[0];
    assign w_sub_in = w_even ? rot_word(r_win[31:0]) : r_win[31:0];

    for (genvar g = 0; g < 4; g++) begin : g_sub
        sbox u_sbox (.i_byte(w_sub_in[8*g +: 8]), .o_byte(w_sub[8*g +: 8]));
    end

    assign w_temp = w_sub ^ (w_even ? {r_rcon, 24'h0} : 32'h0);
    assign w_n0   = r_win[255:224] ^ w_temp;
    assign w_n1   = r_win[223:192] ^ w_n0;
    assign w_n2   = r_win[191:160] ^ w_n1;
    assign w_n3   = r_win[159:128] ^ w_n2;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= IDLE;
            r_win    <= '0;
            r_rcon   <= '0;
            busy     <= 1'b0;
            rk_valid <= 1'b0;
            rk_idx   <= '0;
            rk       <= '0;
            done     <= 1'b0;
        end else begin
            case (r_state)
                IDLE: if (start) begin
                    r_win    <= key;
                    r_rcon   <= RCON_INIT;
                    rk       <= key[255:128];
                    rk_idx   <= '0;
                    rk_valid <= 1'b1;
                    busy     <= 1'b1;
                    done     <= 1'b0;
                    r_state  <= EMIT;
                end
                EMIT: if (rk_ready) begin
                    if (rk_idx == 4'd0) begin
                        rk     <= r_win[127:0];
                        rk_idx <= 4'd1;
                    end else if (rk_idx == 4'(NR)) begin
                        rk_valid <= 1'b0;
                        busy     <= 1'b0;
                        done     <= 1'b0;
                        r_state  <= IDLE;
                    end else begin
                        rk_valid <= 1'b0;
                        r_state  <= GEN;
                    end
                end
                GEN: begin
                    r_win    <= {r_win[127:0], w_n0, w_n1, w_n2, w_n3};
                    rk       <= {w_n0, w_n1, w_n2, w_n3};
                    rk_idx   <= rk_idx + 4'd1;
                    done     <= (rk_idx == 4'(NR - 1));
                    rk_valid <= 1'b1;
                    if (w_even) r_rcon <= xtime(r_rcon);
                    r_state  <= EMIT;
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_aes256_key_expand.sv
// tb_aes256_key_expand: directed + randomized bench against a word-array FIPS-197 key schedule model.
module tb_aes256_key_expand;
    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           start = 1'b0;
    logic           rk_ready = 1'b0;
    logic [255:0]   key = '0;
    logic           busy, rk_valid, done;
    logic [3:0]     rk_idx;
    logic [127:0]   rk;

    int             n_chk = 0;
    int             n_err = 0;
    int             last_cyc = 0;
    logic [7:0]     m_sbox [256];
    logic [127:0]   exp_rk [15];
    logic [127:0]   got_rk [15];

    localparam logic [255:0] KEY_A3 =
        256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;

    aes256_key_expand dut (
        .clk(clk), .rst(rst), .start(start), .key(key), .busy(busy),
        .rk_valid(rk_valid), .rk_ready(rk_ready), .rk_idx(rk_idx), .rk(rk), .done(done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] expv);
        n_chk++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s: got %h want %h", tag, obs, expv);
        end
    endtask

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl(input logic [7:0] v, input int n);
        return (v << n) | (v >> (8 - n));
    endfunction

    // S-box built from its definition: GF(2^8) inverse followed by the affine map.
    task automatic build_sbox();
        logic [7:0] inv;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            m_sbox[x] = inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
        end
    endtask

    function automatic logic [31:0] sub(input logic [31:0] v);
        return {m_sbox[v[31:24]], m_sbox[v[23:16]], m_sbox[v[15:8]], m_sbox[v[7:0]]};
    endfunction

    task automatic expand(input logic [255:0] k);
        logic [31:0] w [60];
        logic [31:0] t;
        logic [7:0]  rc;
        rc = 8'h01;
        for (int i = 0; i < 8; i++) w[i] = k[255 - 32*i -: 32];
        for (int i = 8; i < 60; i++) begin
            t = w[i-1];
            if (i % 8 == 0) begin
                t  = sub({t[23:0], t[31:24]}) ^ {rc, 24'h0};
                rc = gmul(rc, 8'h02);
            end else if (i % 8 == 4) begin
                t = sub(t);
            end
            w[i] = w[i-8] ^ t;
        end
        for (int r = 0; r < 15; r++) exp_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    function automatic logic [255:0] rand_key();
        return {$urandom(), $urandom(), $urandom(), $urandom(),
                $urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    // Called at a negedge; start is driven for the following posedge.
    task automatic run_key(input logic [255:0] k, input bit rnd, input int inj);
        int got = 0;
        int cyc = 1;
        bit injected = 1'b0;
        bit pv = 1'b0;
        bit pr = 1'b0;
        logic [127:0] prk = '0;
        logic [3:0] pidx = '0;
        expand(k);
        start = 1'b1;
        key = k;
        rk_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        key = '0;
        chk("first_valid", 256'(rk_valid), 256'(1));
        chk("first_busy", 256'(busy), 256'(1));
        while (got < 15 && cyc < 400) begin
            start = 1'b0;
            rk_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if (pv && !pr) begin
                chk("stall_valid", 256'(rk_valid), 256'(1));
                chk("stall_rk", 256'(rk), 256'(prk));
                chk("stall_idx", 256'(rk_idx), 256'(pidx));
            end
            if (rk_valid) begin
                chk("rk", 256'(rk), 256'(exp_rk[got]));
                chk("idx", 256'(rk_idx), 256'(got));
                chk("done", 256'(done), 256'(got == 14));
                chk("busy", 256'(busy), 256'(1));
                got_rk[got] = rk;
                if (!injected && got == inj) begin
                    start = 1'b1;
                    key = '0;
                    injected = 1'b1;
                end
                if (rk_ready) begin
                    if (got == 14) last_cyc = cyc;
                    got++;
                end
            end
            pv = rk_valid;
            pr = rk_ready;
            prk = rk;
            pidx = rk_idx;
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
        chk("all_keys", 256'(got), 256'(15));
        chk("end_valid", 256'(rk_valid), 256'(0));
        chk("end_busy", 256'(busy), 256'(0));
    endtask

    initial begin
        build_sbox();
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("rst_busy", 256'(busy), 256'(0));
        chk("rst_valid", 256'(rk_valid), 256'(0));
        chk("rst_idx", 256'(rk_idx), 256'(0));
        chk("rst_rk", 256'(rk), 256'(0));
        chk("rst_done", 256'(done), 256'(0));
        rst = 1'b0;
        @(negedge clk);

        run_key(KEY_A3, 1'b0, -1);
        chk("a3_idx0", 256'(got_rk[0]), 256'(128'h603deb1015ca71be2b73aef0857d7781));
        chk("a3_idx1", 256'(got_rk[1]), 256'(128'h1f352c073b6108d72d9810a30914dff4));
        chk("a3_idx2", 256'(got_rk[2]), 256'(128'h9ba354118e6925afa51a8b5f2067fcde));
        chk("a3_idx3", 256'(got_rk[3]), 256'(128'ha8b09c1a93d194cdbe49846eb75d5b9a));
        chk("a3_idx14", 256'(got_rk[14]), 256'(128'hfe4890d1e6188d0b046df344706c631e));
        chk("a3_lat14", 256'(last_cyc), 256'(28));

        // Back-to-back: each run starts in the cycle busy has just fallen.
        run_key(KEY_A3, 1'b1, -1);
        run_key(KEY_A3, 1'b1, 5);
        run_key(rand_key(), 1'b0, 14);

        start = 1'b1;
        key = KEY_A3;
        rk_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 100 && !(rk_valid && rk_idx == 4'd7); i++) @(negedge clk);
        chk("mid_idx7", 256'(rk_idx), 256'(7));
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("mid_rst_valid", 256'(rk_valid), 256'(0));
        chk("mid_rst_busy", 256'(busy), 256'(0));
        chk("mid_rst_rk", 256'(rk), 256'(0));
        chk("mid_rst_idx", 256'(rk_idx), 256'(0));
        @(negedge clk);
        chk("post_rst_valid", 256'(rk_valid), 256'(0));
        run_key(rand_key(), 1'b1, -1);

        run_key('0, 1'b0, -1);
        chk("zero_idx2", 256'(got_rk[2]), 256'(128'h62636363626363636263636362636363));

        for (int n = 0; n < 3; n++) run_key(rand_key(), 1'b1, -1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule

// File: doc/aes256_key_expand.md
Name: aes256_key_expand

Overview:
- Sequential AES-256 key expansion engine for the encryption datapath.
- Accepts a 256-bit cipher key and emits the 15 round keys (idx 0..14) in order, one 128-bit key per accepted transfer.
- Uses forward S-box lookups for SubWord; it is the forward-direction counterpart to the decryption path's inverse S-box.
- Sits between the key register and the encryption round pipeline. It also feeds the decryption key store, which consumes the keys in reverse order.

Parameters:
- NR, 14: number of rounds; round key indices 0..NR. Fixed for AES-256, not overridable.
- NK, 8: key length in 32-bit words. Fixed.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request expansion of key; accepted only when busy=0.
- key  input  256  cipher key; key[255:224]=w0 ... key[31:0]=w7; sampled on the accepted start cycle only.
- busy  output  1  high from the cycle after accepted start until the cycle after the final transfer.
- rk_valid  output  1  round key available.
- rk_ready  input  1  downstream accepts the round key; a transfer occurs when rk_valid && rk_ready.
- rk_idx  output  4  index of the presented round key, 0..14.
- rk  output  128  round key; rk[127:96]=w[4*idx] ... rk[31:0]=w[4*idx+3].
- done  output  1  high with rk_valid on idx 14 (marks the last key, not a separate pulse).

Behaviour:
- Reset:
  - busy=0, rk_valid=0, rk_idx=0, rk=0, done=0.
  - Internal 256-bit window register and rcon register cleared; FSM goes to IDLE.
- FSM states: IDLE, EMIT, GEN.
- IDLE:
  - On start=1, load the window with key, set rk_idx=0 and rk=key[255:128].
  - Assert rk_valid and busy the next cycle; go to EMIT.
  - With start=0, hold.
- EMIT (rk_valid=1): rk, rk_idx and done are held stable until a transfer.
  - Transfer at idx 0: present key[127:0] with idx 1 next cycle; stay in EMIT.
  - Transfer at idx 1..13: go to GEN.
  - Transfer at idx 14: go to IDLE; rk_valid and busy drop the next cycle.
- GEN (one cycle, rk_valid=0):
  - Compute 4 new words from the 8-word window (w[i-8..i-1]).
  - Even new idx: temp = SubWord(RotWord(w[i-1])) ^ {rcon,24'h0}.
  - Odd new idx: temp = SubWord(w[i-1]).
  - w[i] = w[i-8]^temp; w[i+1] = w[i-7]^w[i]; w[i+2] = w[i-6]^w[i+1]; w[i+3] = w[i-5]^w[i+2].
  - Shift the window by 4 words, present the new key with rk_idx+1, go to EMIT.
- Latency with rk_ready held high:
  - idx 0 valid 1 cycle after start.
  - idx 1 on the next cycle.
  - Each later key takes 2 cycles (GEN + EMIT); idx 14 appears 28 cycles after start.
- rcon:
  - Init 8'h01; used at idx 2,4,...,14, giving 01,02,04,08,10,20,40.
  - Updated by xtime (left shift, xor 8'h1b on carry) after each even-idx generation. Never exceeds 8'h40 for AES-256.
- SubWord uses 4 parallel forward S-box lookups, combinational within the GEN cycle.
- start while busy=1 is ignored: key is not resampled and the sequence is unaffected.
- start in the same cycle as the final transfer (idx 14) is ignored; start is re-accepted only when busy=0.
- rk_ready held low stalls indefinitely in EMIT with outputs stable; no keys are dropped or skipped.
- rst mid-sequence, in any state including a stall, returns to reset values the next cycle with no further transfers.
- rk_idx never wraps past 14.

Decomposition:
- Shared package aes_pkg holds:
  - localparams NR=14, NK=8, RCON_INIT=8'h01, XTIME_POLY=8'h1b.
  - Functions rot_word and xtime.
  - A word_t (32-bit) typedef.
- One natural sub-module, sbox: the combinational forward S-box, byte in, byte out. Instantiate it 4 times for SubWord.
- The FSM, window register and rcon register stay in aes256_key_expand.

Test Plan:
- FIPS-197 A.3 key 603deb10 15ca71be 2b73aef0 857d7781 1f352c07 3b6108d7 2d9810a3 0914dff4, rk_ready=1 ->
  - idx0 = 603deb1015ca71be2b73aef0857d7781.
  - idx1 = 1f352c073b6108d72d9810a30914dff4.
  - idx2 = 9ba354118e6925afa51a8b5f2067fcde.
  - idx3 = a8b09c1a93d194cdbe49846eb75d5b9a.
  - idx14 = fe4890d1e6188d0b046df344706c631e, with done=1 at idx14 and first valid 1 cycle after start.
- Same key, rk_ready toggled pseudo-randomly ->
  - Identical 15-key sequence in order.
  - rk/rk_idx stable on every stalled cycle.
- start pulsed with key=0 at idx 5 of a running sequence -> ignored; remaining keys match the A.3 vector.
- rst asserted while presenting idx 7 -> next cycle rk_valid=0, busy=0, rk=0. A fresh start then yields idx0 of the new key 1 cycle later.
- All-zero key -> idx2 = 62636363626363636263636362636363 (Rcon 01 and SubWord(0)=63 path).
- Back-to-back: start in the cycle busy falls -> accepted, idx0 of the second key valid next cycle.
